mem_sort_engine: RTL and testbench

MEM_SORT_ENGINE -- requirements
Module: mem_sort_engine

---
 rtl/mem_sort_engine.sv | 103 ++++++++++
 tb/tb_mem_sort_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_sort_engine.sv
// mem_sort_engine: in-place bubble sort over a register-array memory with a load port,
// a registered readback port and a busy/done handshake.
module mem_sort_engine #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              descend,
    output logic              busy,
    output logic              flag,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, l_q, l_d, i_nx;
    logic              s_q, s_d, desc_q, desc_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q, a, b;
    logic [ADDR_W:0]   n;
    logic              scan, swap, last;

    always_comb begin
        scan    = state_q == SCAN;
        i_nx    = i_q + ADDR_W'(1);
        a       = mem_q[i_q];
        b       = mem_q[i_nx];
        swap    = scan && l_q != '0 && (desc_q ? a < b : a > b);
        last    = i_nx == l_q;
        n       = (32'(cnt) > DEPTH) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(cnt);
        state_d = state_q;
        i_d     = i_q;
        l_d     = l_q;
        s_d     = s_q;
        desc_d  = desc_q;
        if (!scan && start) begin
            // A limit of zero marks a trivial sort: one busy cycle, then done.
            state_d = SCAN;
            desc_d  = descend;
            i_d     = '0;
            s_d     = 1'b0;
            l_d     = (n < (ADDR_W+1)'(2)) ? '0 : ADDR_W'(n - (ADDR_W+1)'(1));
        end else if (scan) begin
            if (l_q == '0) begin
                state_d = DONE;
            end else if (last) begin
                if (!(s_q || swap) || l_q == ADDR_W'(1)) begin
                    state_d = DONE;
                end else begin
                    l_d = l_q - ADDR_W'(1);
                    i_d = '0;
                    s_d = 1'b0;
                end
            end else begin
                i_d = i_nx;
                s_d = s_q | swap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            l_q     <= '0;
            s_q     <= 1'b0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            l_q     <= l_d;
            s_q     <= s_d;
            desc_q  <= desc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
            if (wr_en && !scan) mem_q[wr_addr] <= wr_data;
            if (swap) begin
                mem_q[i_q]  <= b;
                mem_q[i_nx] <= a;
            end
        end
    end

    assign busy    = scan;
    assign flag    = state_q == DONE;
    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_mem_sort_engine.sv
// tb_mem_sort_engine: directed vector table plus hand-written corner sequences for mem_sort_engine.
module tb_mem_sort_engine;
    logic       clk = 1'b0;
    logic       rst, wr_en, start, descend, busy, flag;
    logic [4:0] wr_addr, rd_addr;
    logic [3:0] wr_data, rd_data, d;
    logic [5:0] cnt;
    int         errors = 0, checks = 0, lat, bad;
    logic [31:0] got;

    typedef struct {
        int          cnt;
        bit          desc;
        logic [31:0] in_w;
        logic [31:0] exp_w;
        int          lat;
    } vec_t;
    vec_t vecs[7];

    mem_sort_engine dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .cnt(cnt), .descend(descend), .busy(busy), .flag(flag),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [3:0] v);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [3:0] v);
        rd_addr = 5'(a);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic kick(input int c, input bit dsc);
        cnt = 6'(c); descend = dsc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag(input int l0, output int l);
        l = l0;
        while (!flag && l < 1000) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        vecs[0] = '{3, 1'b1, 32'h56789213, 32'h56789123, 4};
        vecs[1] = '{4, 1'b0, 32'h00004321, 32'h00004321, 4};
        vecs[2] = '{1, 1'b0, 32'hEF012345, 32'hEF012345, 2};
        vecs[3] = '{0, 1'b1, 32'hEF012345, 32'hEF012345, 2};
        vecs[4] = '{5, 1'b0, 32'hFFF23144, 32'hFFF44321, 11};
        vecs[5] = '{4, 1'b1, 32'h00007689, 32'h00006789, 6};
        vecs[6] = '{3, 1'b0, 32'h00000222, 32'h00000222, 3};
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; descend = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; cnt = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_flag", 32'(flag), 0);
        check("rst_rd", 32'(rd_data), 0);
        rst = 1'b0;
        read_word(31, d);
        check("rst_mem31", 32'(d), 0);

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 8; k++) write_word(k, vecs[v].in_w[k*4 +: 4]);
            kick(vecs[v].cnt, vecs[v].desc);
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].lat > 1));
            wait_flag(1, lat);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("vec%0d_done_busy", v), 32'(busy), 0);
            got = '0;
            for (int k = 0; k < 8; k++) begin
                read_word(k, d);
                got[k*4 +: 4] = d;
            end
            check($sformatf("vec%0d_mem", v), got, vecs[v].exp_w);
        end

        // Worst-case 24-word sort; words above the sorted range must survive.
        for (int a = 0; a < 32; a++) write_word(a, (a < 24) ? 4'((23 - a) & 15) : 4'hA);
        kick(24, 1'b0);
        wait_flag(1, lat);
        check("big_lat", 32'(lat), 277);
        for (int a = 0; a < 32; a++) begin
            read_word(a, d);
            check($sformatf("big_mem%0d", a), 32'(d), (a < 16) ? 32'(a / 2) : (a < 24) ? 32'(a - 8) : 32'hA);
        end

        // cnt beyond depth clamps to the whole memory.
        for (int a = 0; a < 32; a++) write_word(a, 4'((31 - a) >> 1));
        kick(40, 1'b0);
        wait_flag(1, lat);
        check("clamp_lat", 32'(lat), 497);
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            read_word(a, d);
            if (d !== 4'(a >> 1)) bad++;
        end
        check("clamp_mem_bad", 32'(bad), 0);

        // Write and start in the same idle cycle: the sort sees the new word.
        for (int a = 0; a < 3; a++) write_word(a, 4'(a + 1));
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'd5;
        kick(3, 1'b0);
        wr_en = 1'b0;
        wait_flag(1, lat);
        check("same_cyc_lat", 32'(lat), 4);
        got = '0;
        for (int k = 0; k < 3; k++) begin
            read_word(k, d);
            got[k*4 +: 4] = d;
        end
        check("same_cyc_mem", got, 32'h532);

        // Load and start while busy are ignored.
        for (int k = 0; k < 5; k++) write_word(k, vecs[4].in_w[k*4 +: 4]);
        kick(5, 1'b0);
        @(negedge clk);
        check("dist_busy", 32'(busy), 1);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'hF;
        kick(2, 1'b1);
        wr_en = 1'b0;
        wait_flag(3, lat);
        check("dist_lat", 32'(lat), 11);
        got = '0;
        for (int k = 0; k < 5; k++) begin
            read_word(k, d);
            got[k*4 +: 4] = d;
        end
        check("dist_mem", got, 32'h44321);

        // Reset in the middle of a sort.
        for (int a = 0; a < 24; a++) write_word(a, 4'((23 - a) & 15));
        kick(24, 1'b0);
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_flag", 32'(flag), 0);
        check("mid_rst_rd", 32'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            read_word(a, d);
            if (d !== 4'd0) bad++;
        end
        check("mid_mem_bad", 32'(bad), 0);
        check("mid_after_busy", 32'(busy), 0);
        check("mid_after_flag", 32'(flag), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
